// File: rtl/sync_prefetch_fifo_wconv.sv
// Single-clock prefetch FIFO with asymmetric write/read widths.
// Narrow writes pack into wide lines; wide lines unpack into narrow reads.
module sync_prefetch_fifo_wconv #(
    parameter int          WR_DATA_WIDTH = 16,
    parameter int          RD_DATA_WIDTH = 128,
    parameter int          DEPTH_WIDTH   = 10,
    parameter int unsigned AFULL_THRESH  = 1000,
    parameter int unsigned AEMPTY_THRESH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WR_DATA_WIDTH-1:0] wr_data,
    output logic                     wr_rdy,
    input  logic                     rd_en,
    output logic                     rd_vld,
    output logic [RD_DATA_WIDTH-1:0] rd_data,
    output logic [DEPTH_WIDTH:0]     level,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int LW = (WR_DATA_WIDTH > RD_DATA_WIDTH) ? WR_DATA_WIDTH : RD_DATA_WIDTH;
    localparam int WRATIO = (RD_DATA_WIDTH > WR_DATA_WIDTH) ? RD_DATA_WIDTH / WR_DATA_WIDTH : 1;
    localparam int RRATIO = (WR_DATA_WIDTH > RD_DATA_WIDTH) ? WR_DATA_WIDTH / RD_DATA_WIDTH : 1;
    localparam int DEPTH = 1 << DEPTH_WIDTH;

    logic                 clr;
    logic                 accept;
    logic                 commit;
    logic                 rd_fire;
    logic                 rd_last;
    logic                 pop;
    logic                 vis;
    logic                 load;
    logic [LW-1:0]        wline;
    logic [LW-1:0]        mem [DEPTH];
    logic [LW-1:0]        hd_q;
    logic [DEPTH_WIDTH:0] wptr_q;
    logic [DEPTH_WIDTH:0] wptr_d_q;
    logic [DEPTH_WIDTH:0] rptr_q;
    logic [DEPTH_WIDTH:0] level_q;
    logic                 rdy_q;
    logic                 hd_vld_q;
    logic                 ovf_q;
    logic                 udf_q;

    assign clr     = ~rst_n | flush;
    // level never exceeds DEPTH, so its top bit alone marks "full"
    assign wr_rdy  = rdy_q & ~level_q[DEPTH_WIDTH];
    assign accept  = wr_en & wr_rdy & ~clr;
    assign rd_fire = rd_en & hd_vld_q & ~clr;
    assign pop     = rd_fire & rd_last;
    // the reader sees a committed line one cycle after it is written
    assign vis     = wptr_d_q != rptr_q;
    assign load    = vis & (~hd_vld_q | pop) & ~clr;

    assign rd_vld       = hd_vld_q;
    assign level        = level_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;
    assign almost_full  = 32'(level_q) >= AFULL_THRESH;
    assign almost_empty = 32'(level_q) <= AEMPTY_THRESH;

    if (WRATIO > 1) begin : g_pack
        localparam int WLW = $clog2(WRATIO);
        logic [WLW-1:0]              wl_q;
        logic [LW-WR_DATA_WIDTH-1:0] pack_q;

        assign commit = accept & (wl_q == WLW'(WRATIO - 1));
        assign wline  = {wr_data, pack_q};

        // gather narrow words into the lower lanes until the top lane arrives
        always_ff @(posedge clk) begin
            if (clr) begin
                wl_q   <= '0;
                pack_q <= '0;
            end else if (accept) begin
                wl_q <= wl_q + 1'b1;
                if (!commit)
                    pack_q[int'(wl_q)*WR_DATA_WIDTH +: WR_DATA_WIDTH] <= wr_data;
            end
        end
    end else begin : g_nopack
        assign commit = accept;
        assign wline  = wr_data;
    end

    if (RRATIO > 1) begin : g_unpack
        localparam int RLW = $clog2(RRATIO);
        logic [RLW-1:0] rk_q;

        assign rd_last = rk_q == RLW'(RRATIO - 1);
        assign rd_data = hd_q[int'(rk_q)*RD_DATA_WIDTH +: RD_DATA_WIDTH];

        // step through the head line one narrow lane per read
        always_ff @(posedge clk) begin
            if (clr)
                rk_q <= '0;
            else if (rd_fire)
                rk_q <= rk_q + 1'b1;
        end
    end else begin : g_nounpack
        assign rd_last = 1'b1;
        assign rd_data = hd_q;
    end

    // line storage, contents survive reset and flush
    always_ff @(posedge clk) begin
        if (commit)
            mem[wptr_q[DEPTH_WIDTH-1:0]] <= wline;
    end

    // write pointer and its delayed copy seen by the prefetch side
    always_ff @(posedge clk) begin
        if (clr) begin
            wptr_q   <= '0;
            wptr_d_q <= '0;
        end else begin
            wptr_d_q <= wptr_q;
            if (commit)
                wptr_q <= wptr_q + 1'b1;
        end
    end

    // prefetch stage: refill whenever empty or being popped
    always_ff @(posedge clk) begin
        if (clr) begin
            rptr_q   <= '0;
            hd_q     <= '0;
            hd_vld_q <= 1'b0;
        end else if (load) begin
            rptr_q   <= rptr_q + 1'b1;
            hd_q     <= mem[rptr_q[DEPTH_WIDTH-1:0]];
            hd_vld_q <= 1'b1;
        end else if (pop) begin
            hd_vld_q <= 1'b0;
        end
    end

    // committed line count including the prefetch stage
    always_ff @(posedge clk) begin
        if (clr)
            level_q <= '0;
        else begin
            unique case ({commit, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // ready comes up one cycle after reset release; error pulses
    always_ff @(posedge clk) begin
        rdy_q <= rst_n;
        if (clr) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= wr_en & ~wr_rdy;
            udf_q <= rd_en & ~hd_vld_q;
        end
    end

endmodule

// File: tb/tb_sync_prefetch_fifo_wconv.sv
// Bench for sync_prefetch_fifo_wconv: upsize 16->128 and downsize 64->16.
// Queue-based line model checks every output every cycle.
module tb_sync_prefetch_fifo_wconv;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;

    logic         wa = 1'b0;
    logic [15:0]  da = '0;
    logic         ra = 1'b0;
    logic         wr_rdy_a, rd_vld_a, af_a, ae_a, ovf_a, udf_a;
    logic [127:0] rd_data_a;
    logic [10:0]  level_a;

    logic         wb = 1'b0;
    logic [63:0]  db = '0;
    logic         rb = 1'b0;
    logic         wr_rdy_b, rd_vld_b, af_b, ae_b, ovf_b, udf_b;
    logic [15:0]  rd_data_b;
    logic [4:0]   level_b;

    always #5 clk = ~clk;

    sync_prefetch_fifo_wconv u_up (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .wr_en(wa), .wr_data(da), .wr_rdy(wr_rdy_a),
        .rd_en(ra), .rd_vld(rd_vld_a), .rd_data(rd_data_a),
        .level(level_a), .almost_full(af_a), .almost_empty(ae_a),
        .overflow(ovf_a), .underflow(udf_a)
    );

    sync_prefetch_fifo_wconv #(
        .WR_DATA_WIDTH(64), .RD_DATA_WIDTH(16), .DEPTH_WIDTH(4),
        .AFULL_THRESH(14), .AEMPTY_THRESH(2)
    ) u_dn (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .wr_en(wb), .wr_data(db), .wr_rdy(wr_rdy_b),
        .rd_en(rb), .rd_vld(rd_vld_b), .rd_data(rd_data_b),
        .level(level_b), .almost_full(af_b), .almost_empty(ae_b),
        .overflow(ovf_b), .underflow(udf_b)
    );

    typedef struct { logic [127:0] d; int c; } la_t;
    typedef struct { logic [63:0] d; int c; } lb_t;

    la_t          qa[$];
    lb_t          qb[$];
    logic [127:0] packa = '0;
    int           lanea = 0;
    int           rlb = 0;
    int           cyc = 0;
    bit           outr = 0;
    int           errors = 0;
    int           checks = 0;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one clock: advance both models by the rules, then compare everything
    task automatic tick();
        bit va, oka, vb, okb;
        bit eoa, eua, eob, eub;
        logic [63:0] hb;
        va  = qa.size() > 0 && qa[0].c + 2 <= cyc;
        oka = outr && qa.size() < 1024;
        vb  = qb.size() > 0 && qb[0].c + 2 <= cyc;
        okb = outr && qb.size() < 16;
        eoa = 0; eua = 0; eob = 0; eub = 0;
        @(posedge clk);
        cyc++;
        if (!rst_n || flush) begin
            qa.delete();
            qb.delete();
            packa = '0;
            lanea = 0;
            rlb = 0;
            outr = rst_n;
        end else begin
            outr = 1;
            eoa = wa && !oka;
            eua = ra && !va;
            if (ra && va) void'(qa.pop_front());
            if (wa && oka) begin
                packa[lanea*16 +: 16] = da;
                lanea++;
                if (lanea == 8) begin
                    qa.push_back('{d: packa, c: cyc});
                    lanea = 0;
                end
            end
            eob = wb && !okb;
            eub = rb && !vb;
            if (rb && vb) begin
                rlb++;
                if (rlb == 4) begin
                    void'(qb.pop_front());
                    rlb = 0;
                end
            end
            if (wb && okb) qb.push_back('{d: db, c: cyc});
        end
        #1;
        va = qa.size() > 0 && qa[0].c + 2 <= cyc;
        vb = qb.size() > 0 && qb[0].c + 2 <= cyc;
        chk("a_level", level_a, qa.size());
        chk("a_wr_rdy", wr_rdy_a, outr && qa.size() < 1024);
        chk("a_rd_vld", rd_vld_a, va);
        chk("a_ovf", ovf_a, eoa);
        chk("a_udf", udf_a, eua);
        chk("a_afull", af_a, qa.size() >= 1000);
        chk("a_aempty", ae_a, qa.size() <= 4);
        if (va) chk("a_data", rd_data_a, qa[0].d);
        chk("b_level", level_b, qb.size());
        chk("b_wr_rdy", wr_rdy_b, outr && qb.size() < 16);
        chk("b_rd_vld", rd_vld_b, vb);
        chk("b_ovf", ovf_b, eob);
        chk("b_udf", udf_b, eub);
        chk("b_afull", af_b, qb.size() >= 14);
        chk("b_aempty", ae_b, qb.size() <= 2);
        if (vb) begin
            hb = qb[0].d;
            chk("b_data", rd_data_b, hb[rlb*16 +: 16]);
        end
    endtask

    initial begin
        // reset state
        tick();
        tick();
        chk("rst_data_a", rd_data_a, 128'h0);
        chk("rst_data_b", rd_data_b, 16'h0);
        chk("rst_rdy_a", wr_rdy_a, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("rel_rdy_a", wr_rdy_a, 1'b1);

        // eight writes pack one line, visible two cycles after commit
        for (int i = 1; i <= 8; i++) begin
            wa = 1'b1;
            da = 16'(i);
            tick();
        end
        wa = 1'b0;
        chk("t1_level", level_a, 11'd1);
        tick();
        tick();
        chk("t1_vld", rd_vld_a, 1'b1);
        chk("t1_data", rd_data_a, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        ra = 1'b1;
        tick();
        ra = 1'b0;

        // fill to capacity, overflow once, then drain in order
        wa = 1'b1;
        for (int i = 0; i < 8192; i++) begin
            da = 16'($urandom);
            tick();
        end
        wa = 1'b0;
        chk("t2_rdy", wr_rdy_a, 1'b0);
        chk("t2_level", level_a, 11'd1024);
        chk("t2_af", af_a, 1'b1);
        wa = 1'b1;
        tick();
        wa = 1'b0;
        chk("t2_ovf", ovf_a, 1'b1);
        tick();
        chk("t2_ovf_end", ovf_a, 1'b0);
        chk("t2_level_hold", level_a, 11'd1024);
        ra = 1'b1;
        for (int n = 0; n < 1100 && qa.size() > 0; n++) tick();
        ra = 1'b0;
        chk("t2_drained", level_a, 11'd0);
        tick();
        chk("t2_vld_end", rd_vld_a, 1'b0);

        // continuous writes with reads held, then random traffic
        wa = 1'b1;
        ra = 1'b1;
        for (int i = 0; i < 200; i++) begin
            da = 16'($urandom);
            tick();
        end
        for (int i = 0; i < 2000; i++) begin
            wa = $urandom_range(0, 9) < 7;
            ra = $urandom_range(0, 9) < 2;
            da = 16'($urandom);
            tick();
        end
        wa = 1'b0;
        ra = 1'b1;
        for (int n = 0; n < 1100 && qa.size() > 0; n++) tick();
        tick();
        tick();
        chk("t3_udf", udf_a, 1'b1);
        ra = 1'b0;
        tick();

        // partial line discarded by flush with a concurrent write
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wa = 1'b1;
            da = 16'hAA00 + 16'(i);
            tick();
        end
        flush = 1'b1;
        da = 16'hDEAD;
        tick();
        flush = 1'b0;
        wa = 1'b0;
        chk("t5_level", level_a, 11'd0);
        chk("t5_vld", rd_vld_a, 1'b0);
        chk("t5_rdy", wr_rdy_a, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            wa = 1'b1;
            da = 16'h0010 + 16'(i);
            tick();
        end
        wa = 1'b0;
        tick();
        tick();
        chk("t5_data", rd_data_a, 128'h0018_0017_0016_0015_0014_0013_0012_0011);
        ra = 1'b1;
        tick();
        ra = 1'b0;

        // downsize: one wide write read back as four narrow lanes
        wb = 1'b1;
        db = 64'h0004_0003_0002_0001;
        tick();
        wb = 1'b0;
        tick();
        tick();
        chk("t4_vld", rd_vld_b, 1'b1);
        for (int k = 0; k < 4; k++) begin
            chk("t4_data", rd_data_b, 16'(k + 1));
            chk("t4_level", level_b, 5'd1);
            rb = 1'b1;
            tick();
        end
        rb = 1'b0;
        chk("t4_level_end", level_b, 5'd0);
        for (int i = 0; i < 40; i++) begin
            wb = $urandom_range(0, 1) == 1;
            rb = $urandom_range(0, 3) != 0;
            db = {$urandom, $urandom};
            tick();
        end
        wb = 1'b0;
        rb = 1'b1;
        for (int n = 0; n < 100 && qb.size() > 0; n++) tick();
        rb = 1'b0;
        tick();

        // reset in the middle of a burst
        wa = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            da = 16'($urandom);
            tick();
        end
        chk("t6_level", level_a, 11'd500);
        rst_n = 1'b0;
        tick();
        chk("t6_vld", rd_vld_a, 1'b0);
        chk("t6_data", rd_data_a, 128'h0);
        chk("t6_lvl0", level_a, 11'd0);
        chk("t6_ae", ae_a, 1'b1);
        chk("t6_af", af_a, 1'b0);
        chk("t6_ovf", ovf_a, 1'b0);
        chk("t6_udf", udf_a, 1'b0);
        chk("t6_rdy", wr_rdy_a, 1'b0);
        rst_n = 1'b1;
        wa = 1'b0;
        tick();
        chk("t6_rdy_rel", wr_rdy_a, 1'b1);
        for (int i = 0; i < 8; i++) begin
            wa = 1'b1;
            da = 16'($urandom);
            tick();
        end
        wa = 1'b0;
        ra = 1'b1;
        for (int n = 0; n < 10; n++) tick();
        ra = 1'b0;
        chk("t6_empty", level_a, 11'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sync_prefetch_fifo_wconv.md
Name: sync_prefetch_fifo_wconv

Overview:
Single-clock first-word-fall-through (prefetch) FIFO with parametrised asymmetric data widths, for the user-side DDR3 read/write path.
- Upsize mode (WR_DATA_WIDTH < RD_DATA_WIDTH): packs narrow writes into wide lines, e.g. 16-bit pixel stream to 128-bit DDR burst word.
- Downsize mode (WR_DATA_WIDTH > RD_DATA_WIDTH): unpacks wide lines into narrow reads.
- Equal widths behave as a plain FIFO.
- Adds beyond the previous generation: synchronous flush, fill level, programmable almost-full/almost-empty thresholds, and overflow/underflow flags.

Parameters:
WR_DATA_WIDTH, 16, write word width; the larger of WR_DATA_WIDTH/RD_DATA_WIDTH is a power-of-two multiple (1,2,4,8,16) of the smaller.
RD_DATA_WIDTH, 128, read word width.
DEPTH_WIDTH, 10, log2 of capacity in lines; LW = max(WR,RD) bits per line, capacity = 2^DEPTH_WIDTH lines.
AFULL_THRESH, 1000, almost_full asserts when level >= this value.
AEMPTY_THRESH, 4, almost_empty asserts when level <= this value.

Ports:
clk  in  1  single clock; all logic on rising edge.
rst_n  in  1  reset: synchronous, active-low.
flush  in  1  synchronous clear, active-high.
wr_en  in  1  write request.
wr_data  in  WR_DATA_WIDTH  write word.
wr_rdy  out  1  write accepted this cycle if wr_en=1.
rd_en  in  1  consume current rd_data.
rd_vld  out  1  rd_data valid (prefetched head).
rd_data  out  RD_DATA_WIDTH  head word.
level  out  DEPTH_WIDTH+1  committed lines held, including prefetch stage.
almost_full  out  1  level >= AFULL_THRESH.
almost_empty  out  1  level <= AEMPTY_THRESH.
overflow  out  1  one-cycle pulse: wr_en while wr_rdy=0.
underflow  out  1  one-cycle pulse: rd_en while rd_vld=0.

Behaviour:
- Reset (rst_n=0 at edge): pointers, pack/unpack lane counters, prefetch stage and level cleared.
  - Outputs: rd_vld=0, rd_data=0, level=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, wr_rdy=0.
  - wr_rdy=1 from the first cycle after rst_n=1 is sampled.
- flush=1: same effect as reset, except wr_rdy stays 1. Takes priority over wr_en/rd_en in the same cycle. Memory contents need not be cleared.
- Write acceptance: accept = wr_en & wr_rdy. wr_rdy = (level < 2^DEPTH_WIDTH). wr_rdy never depends on same-cycle rd_en (no full pass-through).
- Upsize packing:
  - Accepted words fill lanes 0..RATIO-1, first word in LSBs.
  - The RATIO-th accepted word commits the line; level increments at that edge.
  - Partial lines are invisible to the reader and not counted in level.
  - When level = 2^DEPTH_WIDTH, wr_rdy=0 even if the pack register is partially filled.
- Downsize/equal: every accepted write commits one line.
- Prefetch latency: a line committed at edge T shows rd_vld=1 with its data after edge T+2 when the FIFO was empty.
- Throughput: sustained rd_en=1 yields one read word per clock with no bubbles while data is present.
- Downsize unpacking: rd_data = lane k of the head line, lane 0 (LSBs) first. rd_en with rd_vld advances k; at k=RATIO-1 the line pops and level decrements.
- Upsize read: each rd_en with rd_vld pops one line.
- rd_en while rd_vld=0 is ignored; underflow pulses for 1 cycle.
- wr_en while wr_rdy=0: data dropped; overflow pulses for 1 cycle.
- Simultaneous commit and pop in one cycle: level unchanged.
- almost_full and almost_empty are combinational from level and update in the same cycle as level.
- Pointer wrap at 2^DEPTH_WIDTH is seamless.
- rd_data holds its value while rd_vld=1 and rd_en=0.

Test Plan:
1. Defaults; write 0x0001..0x0008 consecutively, rd_en=0 -> level=1 after the 8th write; 2 cycles later rd_vld=1 with rd_data=0x0008_0007_0006_0005_0004_0003_0002_0001.
2. Fill 8192 words with no reads -> wr_rdy falls after the 8192nd acceptance, level=1024, almost_full=1; a further wr_en pulses overflow once and level stays 1024; drain all -> 1024 reads in order, then rd_vld=0, level=0.
3. Continuous writes with rd_en=1 held -> one 128-bit word every 8 clocks, no loss; rd_en at rd_vld=0 -> underflow pulse, no pointer change.
4. Downsize WR=64, RD=16: write 0x0004_0003_0002_0001 -> reads 0x0001, 0x0002, 0x0003, 0x0004 on consecutive rd_en cycles; level goes 1 -> 0 on the 4th.
5. Write 3 words (partial line), then flush together with wr_en -> level=0, rd_vld=0; 8 new words form a line free of the old partial data.
6. rst_n=0 mid-burst at level=500 -> next cycle all outputs at reset values, wr_rdy=0; after release wr_rdy=1 and the FIFO operates from empty.
